// File: rtl/lcd_rx.sv
// Receive-side decoder for the 8-bit serial-RGB LCD bus: assembles R,G,B bytes
// into 24-bit pixels with x/y coordinates and checks line/frame geometry.
module lcd_rx #(
   parameter int H_ACTIVE = 320,
   parameter int V_ACTIVE = 240
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  lcd_dat,
   input  logic        lcd_hsync,
   input  logic        lcd_vsync,
   input  logic        lcd_den,
   output logic        pix_valid,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic [23:0] pix_rgb,
   output logic        frame_start,
   output logic [15:0] frame_count,
   output logic        phase_err,
   output logic        line_err,
   output logic        frame_err
);

   localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT = 12'(V_ACTIVE);

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   // Stage-1 pin registers plus their previous values for edge detection.
   logic [7:0]  dat_r_q, dat_r_d;
   logic        hs_r_q, hs_r_d, vs_r_q, vs_r_d, den_r_q, den_r_d;
   logic        hs_p_q, hs_p_d, vs_p_q, vs_p_d, den_p_q, den_p_d;

   logic [1:0]  ph_q, ph_d;
   logic [11:0] x_q, x_d, y_q, y_d, lc_q, lc_d;
   logic        seen_q, seen_d;
   logic [7:0]  red_q, red_d, grn_q, grn_d;

   logic        pix_valid_q, pix_valid_d;
   logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [23:0] pix_rgb_q, pix_rgb_d;
   logic        frame_start_q, frame_start_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        phase_err_q, phase_err_d, line_err_q, line_err_d;
   logic        frame_err_q, frame_err_d;

   logic        den_fall, hs_fall, vs_fall;
   logic [11:0] lc_end;

   assign den_fall = den_p_q & ~den_r_q;
   assign hs_fall  = hs_p_q & ~hs_r_q;
   assign vs_fall  = vs_p_q & ~vs_r_q;

   always_comb begin
      dat_r_d       = lcd_dat;
      hs_r_d        = lcd_hsync;
      vs_r_d        = lcd_vsync;
      den_r_d       = lcd_den;
      hs_p_d        = hs_r_q;
      vs_p_d        = vs_r_q;
      den_p_d       = den_r_q;
      ph_d          = ph_q;
      x_d           = x_q;
      y_d           = y_q;
      lc_d          = lc_q;
      seen_d        = seen_q;
      red_d         = red_q;
      grn_d         = grn_q;
      pix_valid_d   = 1'b0;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      pix_rgb_d     = pix_rgb_q;
      frame_start_d = 1'b0;
      frame_count_d = frame_count_q;
      phase_err_d   = phase_err_q;
      line_err_d    = line_err_q;
      frame_err_d   = frame_err_q;
      lc_end        = lc_q;

      if (den_r_q) begin
         case (ph_q)
            2'd0: begin
               red_d = dat_r_q;
               ph_d  = 2'd1;
            end
            2'd1: begin
               grn_d = dat_r_q;
               ph_d  = 2'd2;
            end
            2'd2: begin
               pix_valid_d = 1'b1;
               pix_rgb_d   = {red_q, grn_q, dat_r_q};
               pix_x_d     = x_q;
               pix_y_d     = y_q;
               x_d         = sat_inc(x_q);
               ph_d        = 2'd0;
            end
            default: ph_d = 2'd0;
         endcase
      end

      // Line end is resolved before vsync so a coincident frame check sees lc+1.
      if (den_fall) begin
         if (ph_q != 2'd0) phase_err_d = 1'b1;
         if (x_q != H_ACT) line_err_d = 1'b1;
         x_d    = '0;
         ph_d   = 2'd0;
         y_d    = sat_inc(y_q);
         lc_end = sat_inc(lc_q);
         lc_d   = lc_end;
      end

      if (hs_fall) begin
         x_d  = '0;
         ph_d = 2'd0;
      end

      if (vs_fall) begin
         frame_start_d = 1'b1;
         frame_count_d = frame_count_q + 16'd1;
         if (seen_q && (lc_end != V_ACT)) frame_err_d = 1'b1;
         y_d    = '0;
         lc_d   = '0;
         seen_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dat_r_q       <= '0;
         hs_r_q        <= 1'b1;
         vs_r_q        <= 1'b1;
         den_r_q       <= 1'b0;
         hs_p_q        <= 1'b1;
         vs_p_q        <= 1'b1;
         den_p_q       <= 1'b0;
         ph_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         lc_q          <= '0;
         seen_q        <= 1'b0;
         red_q         <= '0;
         grn_q         <= '0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_rgb_q     <= '0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
         phase_err_q   <= 1'b0;
         line_err_q    <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         dat_r_q       <= dat_r_d;
         hs_r_q        <= hs_r_d;
         vs_r_q        <= vs_r_d;
         den_r_q       <= den_r_d;
         hs_p_q        <= hs_p_d;
         vs_p_q        <= vs_p_d;
         den_p_q       <= den_p_d;
         ph_q          <= ph_d;
         x_q           <= x_d;
         y_q           <= y_d;
         lc_q          <= lc_d;
         seen_q        <= seen_d;
         red_q         <= red_d;
         grn_q         <= grn_d;
         pix_valid_q   <= pix_valid_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_rgb_q     <= pix_rgb_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
         phase_err_q   <= phase_err_d;
         line_err_q    <= line_err_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_rgb     = pix_rgb_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;
   assign phase_err   = phase_err_q;
   assign line_err    = line_err_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_lcd_rx.sv
// Bench for lcd_rx with H_ACTIVE=4, V_ACTIVE=3: pixel scoreboard, line-length
// vector table and hand-written latency/frame/reset sequences.
module tb_lcd_rx;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  lcd_dat = '0;
   logic        lcd_hsync = 1'b1;
   logic        lcd_vsync = 1'b1;
   logic        lcd_den = 1'b0;
   logic        pix_valid;
   logic [11:0] pix_x, pix_y;
   logic [23:0] pix_rgb;
   logic        frame_start;
   logic [15:0] frame_count;
   logic        phase_err, line_err, frame_err;

   lcd_rx #(.H_ACTIVE(4), .V_ACTIVE(3)) dut (
      .clock(clock), .reset(reset), .lcd_dat(lcd_dat), .lcd_hsync(lcd_hsync),
      .lcd_vsync(lcd_vsync), .lcd_den(lcd_den), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_start(frame_start),
      .frame_count(frame_count), .phase_err(phase_err), .line_err(line_err),
      .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [23:0] rgb;
   } pix_t;

   typedef struct {
      int   nbytes;
      int   exp_pix;
      logic exp_ph;
      logic exp_ln;
   } vec_t;

   pix_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   pix_cnt = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else
         $display("ok   %s = %0h", name, act);
   endtask

   // Every strobe is matched against the oldest expected pixel.
   always @(negedge clock) begin : mon
      pix_t e;
      if (pix_valid) begin
         pix_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pix_unexpected actual x=%0d y=%0d rgb=%06h required none",
                     pix_x, pix_y, pix_rgb);
         end else begin
            e = exp_q.pop_front();
            if ({pix_x, pix_y, pix_rgb} !== e) begin
               errors++;
               $display("FAIL pix actual x=%0d y=%0d rgb=%06h required x=%0d y=%0d rgb=%06h",
                        pix_x, pix_y, pix_rgb, e.x, e.y, e.rgb);
            end else
               $display("pix  x=%0d y=%0d rgb=%06h", pix_x, pix_y, pix_rgb);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      lcd_den = 1'b0; lcd_hsync = 1'b1; lcd_vsync = 1'b1; lcd_dat = '0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   // Byte i of a line with row y: R=0x10+x, G=0x20+y, B=0x5A.
   task automatic send_px_byte(input int i, input int y);
      int   x;
      pix_t p;
      x = i / 3;
      case (i % 3)
         0:       lcd_dat = 8'(8'h10 + x);
         1:       lcd_dat = 8'(8'h20 + y);
         default: lcd_dat = 8'h5A;
      endcase
      if (i % 3 == 2) begin
         p.x   = 12'(x);
         p.y   = 12'(y);
         p.rgb = {8'(8'h10 + x), 8'(8'h20 + y), 8'h5A};
         exp_q.push_back(p);
      end
      lcd_den = 1'b1;
      tick();
   endtask

   task automatic send_line(input int n, input int y, input bit with_vsync);
      for (int i = 0; i < n; i++) send_px_byte(i, y);
      lcd_den = 1'b0;
      if (with_vsync) lcd_vsync = 1'b0;
      tick();
      lcd_vsync = 1'b1;
      tick();
      lcd_hsync = 1'b0;
      tick();
      lcd_hsync = 1'b1;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic vsync_pulse();
      lcd_vsync = 1'b0;
      tick(); tick();
      lcd_vsync = 1'b1;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic chk_drained(input string name);
      chk(name, 48'(exp_q.size()), 48'd0);
      exp_q.delete();
   endtask

   vec_t tbl[6];
   int   base;

   initial begin
      tbl[0] = '{12, 4, 1'b0, 1'b0};
      tbl[1] = '{13, 4, 1'b1, 1'b0};
      tbl[2] = '{9,  3, 1'b0, 1'b1};
      tbl[3] = '{11, 3, 1'b1, 1'b1};
      tbl[4] = '{15, 5, 1'b0, 1'b1};
      tbl[5] = '{3,  1, 1'b0, 1'b1};

      // Reset state
      do_reset();
      chk("rst_pix", 48'({pix_valid, pix_x, pix_y, pix_rgb}), 48'd0);
      chk("rst_evt", 48'({frame_start, frame_count}), 48'd0);
      chk("rst_err", 48'({phase_err, line_err, frame_err}), 48'd0);

      // Line-length table: one line per vector from a clean reset
      foreach (tbl[k]) begin
         do_reset();
         base = pix_cnt;
         send_line(tbl[k].nbytes, 0, 1'b0);
         chk($sformatf("tbl%0d_strobes", k), 48'(pix_cnt - base), 48'(tbl[k].exp_pix));
         chk($sformatf("tbl%0d_phase_err", k), 48'(phase_err), 48'(tbl[k].exp_ph));
         chk($sformatf("tbl%0d_line_err", k), 48'(line_err), 48'(tbl[k].exp_ln));
         chk_drained($sformatf("tbl%0d_missing", k));
      end

      // Nominal frame
      do_reset();
      base = pix_cnt;
      vsync_pulse();
      for (int y = 0; y < 3; y++) send_line(12, y, 1'b0);
      vsync_pulse();
      chk("nom_strobes", 48'(pix_cnt - base), 48'd12);
      chk("nom_frame_count", 48'(frame_count), 48'd2);
      chk("nom_errs", 48'({phase_err, line_err, frame_err}), 48'd0);
      chk("nom_last_rgb", 48'(pix_rgb), 48'h13225A);
      chk_drained("nom_missing");

      // Pixel latency: B byte captured at edge e1, strobe after edge e2
      do_reset();
      send_px_byte(0, 0);
      send_px_byte(1, 0);
      send_px_byte(2, 0);
      chk("lat_early", 48'(pix_valid), 48'd0);
      lcd_den = 1'b0;
      tick();
      chk("lat_on", 48'(pix_valid), 48'd1);
      tick();
      chk("lat_off", 48'(pix_valid), 48'd0);
      chk_drained("lat_missing");

      // frame_start latency and pulse width
      do_reset();
      lcd_vsync = 1'b0;
      tick();
      chk("fs_early", 48'(frame_start), 48'd0);
      tick();
      chk("fs_on", 48'(frame_start), 48'd1);
      lcd_vsync = 1'b1;
      tick();
      chk("fs_off", 48'(frame_start), 48'd0);
      chk("fs_count", 48'(frame_count), 48'd1);

      // Partial pixel then a clean line
      do_reset();
      send_line(13, 0, 1'b0);
      chk("part_phase_err", 48'(phase_err), 48'd1);
      chk("part_line_err", 48'(line_err), 48'd0);
      send_line(12, 1, 1'b0);
      chk_drained("part_missing");

      // Short frames: first frame unchecked, second flagged
      do_reset();
      send_line(12, 0, 1'b0);
      send_line(12, 1, 1'b0);
      vsync_pulse();
      chk("first_frame_err", 48'(frame_err), 48'd0);
      send_line(12, 0, 1'b0);
      send_line(9, 1, 1'b0);
      chk("short_line_err", 48'(line_err), 48'd1);
      vsync_pulse();
      chk("short_frame_err", 48'(frame_err), 48'd1);
      chk_drained("short_missing");

      // Den fall and vsync fall together on the third line
      do_reset();
      vsync_pulse();
      send_line(12, 0, 1'b0);
      send_line(12, 1, 1'b0);
      send_line(12, 2, 1'b1);
      chk("sim_frame_err", 48'(frame_err), 48'd0);
      chk("sim_frame_count", 48'(frame_count), 48'd2);
      send_line(12, 0, 1'b0);
      chk("sim_next_y", 48'(pix_y), 48'd0);
      chk("sim_line_err", 48'(line_err), 48'd0);
      chk_drained("sim_missing");

      // Asynchronous reset mid-line
      do_reset();
      vsync_pulse();
      send_line(4, 0, 1'b0);
      chk("pre_rst_phase_err", 48'(phase_err), 48'd1);
      for (int i = 0; i < 5; i++) send_px_byte(i, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_pix", 48'({pix_valid, pix_x, pix_y, pix_rgb}), 48'd0);
      chk("arst_evt", 48'({frame_start, frame_count}), 48'd0);
      chk("arst_err", 48'({phase_err, line_err, frame_err}), 48'd0);
      lcd_den = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      exp_q.delete();
      send_line(12, 0, 1'b0);
      chk("arst_after_errs", 48'({phase_err, line_err, frame_err}), 48'd0);
      chk_drained("arst_missing");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
